// File: rtl/cellrv32_xirq_arb_if.sv
// Bundle of CPU bus strobes and XIRQ pending/clear/irq lines seen by the arbiter.
// The arbiter takes the slave side; the bus/pending-buffer side takes the master side.
interface cellrv32_xirq_arb_if #(
    parameter int NUM_CH = 8
);
    logic [31:0]       addr_i;
    logic              rden_i;
    logic              wren_i;
    logic [31:0]       data_i;
    logic [31:0]       data_o;
    logic              ack_o;
    logic [NUM_CH-1:0] pend_i;
    logic [NUM_CH-1:0] pend_clr_o;
    logic              cpu_irq_o;

    modport slave (
        input  addr_i, rden_i, wren_i, data_i, pend_i,
        output data_o, ack_o, pend_clr_o, cpu_irq_o
    );

    modport master (
        output addr_i, rden_i, wren_i, data_i, pend_i,
        input  data_o, ack_o, pend_clr_o, cpu_irq_o
    );
endinterface

// File: rtl/cellrv32_xirq_arb.sv
// Programmable-priority XIRQ arbiter with an in-service stack for nested preemption.
// Software claims the winner by reading CLAIM and retires it by writing its id back.
module cellrv32_xirq_arb #(
    parameter int          NUM_CH     = 8,
    parameter int          PRIO_BITS  = 3,
    parameter int          NEST_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFFF400
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    cellrv32_xirq_arb_if.slave bus
);
    localparam int PW = PRIO_BITS;

    typedef struct packed {
        logic          valid;
        logic [4:0]    id;
        logic [PW-1:0] prio;
    } best_t;

    logic              r_en;
    logic [PW-1:0]     r_thresh;
    logic [PW-1:0]     r_prio    [NUM_CH];
    logic [4:0]        r_stkId   [NEST_DEPTH];
    logic [PW-1:0]     r_stkPrio [NEST_DEPTH];
    logic [3:0]        r_level;
    logic              r_cmplErr;
    logic              r_ovf;
    best_t             r_best;
    logic              r_irq;
    logic              r_ack;
    logic [31:0]       r_rdata;
    logic [NUM_CH-1:0] r_clr;

    logic              w_inWin;
    logic              w_rd;
    logic              w_wr;
    logic [5:0]        w_word;
    logic              w_claimRd;
    logic              w_cmplWr;
    logic              w_empty;
    logic              w_full;
    logic [4:0]        w_topId;
    logic [PW-1:0]     w_topPrio;
    logic [PW-1:0]     w_eff;
    logic [NUM_CH-1:0] w_inStack;
    best_t             w_arb;
    logic              w_push;
    logic              w_claimOvf;
    logic              w_pop;
    logic              w_cmplBad;
    logic [31:0]       w_rdata;
    logic              w_unused;

    assign w_inWin   = (bus.addr_i[31:8] == BASE_ADDR[31:8]);
    assign w_rd      = bus.rden_i & w_inWin;
    assign w_wr      = bus.wren_i & w_inWin;
    assign w_word    = bus.addr_i[7:2];
    assign w_claimRd = w_rd && (w_word == 6'd2);
    assign w_cmplWr  = w_wr && (w_word == 6'd2);
    assign w_empty   = (r_level == 4'd0);
    assign w_full    = (r_level == 4'(NEST_DEPTH));
    assign w_unused  = ^{bus.addr_i, bus.data_i};

    // Stack top and in-stack flags; entries at or above r_level are stale.
    always_comb begin
        w_topId   = '0;
        w_topPrio = '0;
        w_inStack = '0;
        for (int k = 0; k < NEST_DEPTH; k++) begin
            if (r_level == 4'(k + 1)) begin
                w_topId   = r_stkId[k];
                w_topPrio = r_stkPrio[k];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if ((4'(k) < r_level) && (r_stkId[k] == 5'(i)))
                    w_inStack[i] = 1'b1;
            end
        end
        w_eff = (w_topPrio > r_thresh) ? w_topPrio : r_thresh;
    end

    // Strict '>' on the running best keeps the lowest index on priority ties.
    always_comb begin
        w_arb = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.pend_i[i] && (r_prio[i] > w_eff) && !w_inStack[i] &&
                (r_prio[i] > w_arb.prio)) begin
                w_arb.valid = 1'b1;
                w_arb.id    = 5'(i);
                w_arb.prio  = r_prio[i];
            end
        end
    end

    assign w_push     = w_claimRd && r_best.valid && !w_full;
    assign w_claimOvf = w_claimRd && r_best.valid && w_full;
    assign w_pop      = w_cmplWr && !w_empty && (bus.data_i[4:0] == w_topId);
    assign w_cmplBad  = w_cmplWr && !w_pop;

    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (w_word)
                6'd0: w_rdata[0] = r_en;
                6'd1: w_rdata[PW-1:0] = r_thresh;
                6'd2: if (w_push) w_rdata = {1'b1, 26'b0, r_best.id};
                6'd3: begin
                    w_rdata[3:0] = r_level;
                    w_rdata[8]   = r_cmplErr;
                    w_rdata[9]   = r_ovf;
                end
                default: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (w_word == 6'(i + 4))
                            w_rdata[PW-1:0] = r_prio[i];
                    end
                end
            endcase
        end
    end

    // A push or pop invalidates best_q for one cycle so the next pick sees the new stack.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_en      <= 1'b0;
            r_thresh  <= '0;
            r_level   <= '0;
            r_cmplErr <= 1'b0;
            r_ovf     <= 1'b0;
            r_best    <= '0;
            r_irq     <= 1'b0;
            r_ack     <= 1'b0;
            r_rdata   <= '0;
            r_clr     <= '0;
            for (int i = 0; i < NUM_CH; i++)
                r_prio[i] <= '0;
            for (int k = 0; k < NEST_DEPTH; k++) begin
                r_stkId[k]   <= '0;
                r_stkPrio[k] <= '0;
            end
        end else begin
            r_ack   <= (bus.rden_i | bus.wren_i) & w_inWin;
            r_rdata <= w_rdata;
            r_irq   <= r_best.valid & r_en;
            r_best  <= (w_push || w_pop) ? '0 : w_arb;
            for (int i = 0; i < NUM_CH; i++)
                r_clr[i] <= w_push && (r_best.id == 5'(i));

            if (w_wr) begin
                case (w_word)
                    6'd0: r_en <= bus.data_i[0];
                    6'd1: r_thresh <= bus.data_i[PW-1:0];
                    6'd2: ;
                    6'd3: begin
                        if (bus.data_i[8]) r_cmplErr <= 1'b0;
                        if (bus.data_i[9]) r_ovf <= 1'b0;
                    end
                    default: begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (w_word == 6'(i + 4))
                                r_prio[i] <= bus.data_i[PW-1:0];
                        end
                    end
                endcase
            end

            if (w_push) begin
                for (int k = 0; k < NEST_DEPTH; k++) begin
                    if (r_level == 4'(k)) begin
                        r_stkId[k]   <= r_best.id;
                        r_stkPrio[k] <= r_best.prio;
                    end
                end
                r_level <= r_level + 4'd1;
            end
            if (w_pop)
                r_level <= r_level - 4'd1;
            if (w_claimOvf)
                r_ovf <= 1'b1;
            if (w_cmplBad)
                r_cmplErr <= 1'b1;
        end
    end

    assign bus.data_o     = r_rdata;
    assign bus.ack_o      = r_ack;
    assign bus.pend_clr_o = r_clr;
    assign bus.cpu_irq_o  = r_irq;
endmodule

// File: tb/tb_cellrv32_xirq_arb.sv
// Testbench for cellrv32_xirq_arb: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbiter.
module tb_cellrv32_xirq_arb;
    localparam int          NUM_CH     = 8;
    localparam int          PRIO_BITS  = 3;
    localparam int          NEST_DEPTH = 4;
    localparam logic [31:0] BASE       = 32'hFFFFF400;
    localparam logic [31:0] A_CTRL     = BASE;
    localparam logic [31:0] A_THR      = BASE + 32'h04;
    localparam logic [31:0] A_CLAIM    = BASE + 32'h08;
    localparam logic [31:0] A_STAT     = BASE + 32'h0C;
    localparam logic [31:0] A_PRIO     = BASE + 32'h10;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b1;
    always #5 clk_i = ~clk_i;

    cellrv32_xirq_arb_if #(.NUM_CH(NUM_CH)) bus ();

    cellrv32_xirq_arb #(
        .NUM_CH(NUM_CH), .PRIO_BITS(PRIO_BITS), .NEST_DEPTH(NEST_DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .clk_i (clk_i),
        .rstn_i(rstn_i),
        .bus   (bus)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state
    bit                mEn;
    int                mThresh;
    int                mPrio [NUM_CH];
    int                mStkId[$];
    int                mStkPrio[$];
    bit                mCmplErr;
    bit                mOvf;
    bit                mBestV;
    int                mBestId;
    int                mBestPrio;
    bit                mIrq;
    bit                mAck;
    logic [31:0]       mRdata;
    logic [NUM_CH-1:0] mClr;

    task automatic resetModel();
        mEn = 0; mThresh = 0;
        foreach (mPrio[i]) mPrio[i] = 0;
        mStkId.delete(); mStkPrio.delete();
        mCmplErr = 0; mOvf = 0;
        mBestV = 0; mBestId = 0; mBestPrio = 0;
        mIrq = 0; mAck = 0; mRdata = '0; mClr = '0;
    endtask

    // Advance one clock: evaluate the model on the current inputs, then commit after the edge.
    task automatic tick();
        int          eff, maxP, win, word;
        bit          inStk, inWin, pushed, popped;
        bit          nBestV, nAck, nIrq;
        int          nBestId, nBestPrio;
        logic [31:0] a, d, nRd;
        logic [NUM_CH-1:0] nClr;
        a = bus.addr_i; d = bus.data_i;
        eff = mThresh;
        if (mStkPrio.size() > 0 && mStkPrio[$] > eff) eff = mStkPrio[$];
        maxP = 0; win = -1;
        for (int i = 0; i < NUM_CH; i++) begin
            inStk = 0;
            foreach (mStkId[k]) if (mStkId[k] == i) inStk = 1;
            if (bus.pend_i[i] && mPrio[i] > eff && !inStk && mPrio[i] > maxP) begin
                maxP = mPrio[i]; win = i;
            end
        end
        inWin  = (a[31:8] == BASE[31:8]);
        word   = int'(a[7:2]);
        nIrq   = mBestV && mEn;
        nAck   = (bus.rden_i || bus.wren_i) && inWin;
        nRd    = '0; nClr = '0; pushed = 0; popped = 0;
        if (bus.rden_i && inWin) begin
            if (word == 0) nRd = 32'(mEn);
            else if (word == 1) nRd = 32'(mThresh);
            else if (word == 2) begin
                if (mBestV && mStkId.size() < NEST_DEPTH) begin
                    nRd = 32'h8000_0000 | 32'(mBestId);
                    nClr[mBestId] = 1'b1;
                    mStkId.push_back(mBestId); mStkPrio.push_back(mBestPrio);
                    pushed = 1;
                end else if (mBestV) mOvf = 1;
            end else if (word == 3)
                nRd = 32'(mStkId.size()) | (mCmplErr ? 32'h100 : 32'h0) | (mOvf ? 32'h200 : 32'h0);
            else if (word >= 4 && word - 4 < NUM_CH) nRd = 32'(mPrio[word-4]);
        end
        if (bus.wren_i && inWin) begin
            if (word == 0) mEn = d[0];
            else if (word == 1) mThresh = int'(d[PRIO_BITS-1:0]);
            else if (word == 2) begin
                if (mStkId.size() > 0 && mStkId[$] == int'(d[4:0])) begin
                    void'(mStkId.pop_back()); void'(mStkPrio.pop_back()); popped = 1;
                end else mCmplErr = 1;
            end else if (word == 3) begin
                if (d[8]) mCmplErr = 0;
                if (d[9]) mOvf = 0;
            end else if (word >= 4 && word - 4 < NUM_CH) mPrio[word-4] = int'(d[PRIO_BITS-1:0]);
        end
        nBestV    = (win >= 0) && !pushed && !popped;
        nBestId   = nBestV ? win : 0;
        nBestPrio = nBestV ? maxP : 0;
        @(posedge clk_i); #1;
        mBestV = nBestV; mBestId = nBestId; mBestPrio = nBestPrio;
        mIrq = nIrq; mAck = nAck; mRdata = nRd; mClr = nClr;
        bus.pend_i = bus.pend_i & ~mClr;
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        bus.addr_i = a; bus.data_i = d; bus.wren_i = 1'b1;
        tick();
        bus.wren_i = 1'b0;
    endtask

    task automatic busRead(input logic [31:0] a, output logic [31:0] d);
        bus.addr_i = a; bus.rden_i = 1'b1;
        tick();
        d = bus.data_o;
        bus.rden_i = 1'b0;
    endtask

    task automatic doReset();
        rstn_i = 1'b0;
        bus.rden_i = 0; bus.wren_i = 0; bus.addr_i = '0; bus.data_i = '0; bus.pend_i = '0;
        resetModel();
        repeat (2) @(posedge clk_i);
        #1 rstn_i = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bus.rden_i = 0; bus.wren_i = 0; bus.addr_i = '0; bus.data_i = '0; bus.pend_i = '0;
        #3 rstn_i = 1'b0;
        #2;
        testsRun++;
        if ({bus.cpu_irq_o, bus.ack_o, bus.data_o, bus.pend_clr_o} !== '0) begin
            testsFailed++; $display("[TB] FAIL reset_outputs got irq=%b ack=%b data=%h clr=%h exp all 0",
                                    bus.cpu_irq_o, bus.ack_o, bus.data_o, bus.pend_clr_o);
        end
        doReset();
        busRead(A_STAT, d);
        testsRun++; if (d !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_status got=%h exp=0", d); end
        busRead(A_PRIO + 32'd12, d);
        testsRun++; if (d !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_prio3 got=%h exp=0", d); end
    endtask

    task automatic test_bus_map();
        logic [31:0] d;
        doReset();
        busWrite(A_PRIO + 32'd4, 32'hFF);
        busRead(A_PRIO + 32'd4, d);
        testsRun++; if (d !== 32'h7) begin testsFailed++; $display("[TB] FAIL prio_mask got=%h exp=7", d); end
        busWrite(A_PRIO + 32'd36, 32'h5);
        busRead(A_PRIO + 32'd36, d);
        testsRun++; if (d !== 32'h0 || bus.ack_o !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL prio_ch9 got data=%h ack=%b exp data=0 ack=1", d, bus.ack_o); end
        busRead(BASE + 32'h80, d);
        testsRun++; if (d !== 32'h0 || bus.ack_o !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL unmapped got data=%h ack=%b exp data=0 ack=1", d, bus.ack_o); end
        busRead(32'h0000_0008, d);
        testsRun++; if (bus.ack_o !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL out_of_window_ack got=%b exp=0", bus.ack_o); end
    endtask

    task automatic test_t1_basic();
        logic [31:0] d;
        doReset();
        busWrite(A_PRIO + 32'd8, 32'd3);
        busWrite(A_PRIO + 32'd20, 32'd3);
        busWrite(A_CTRL, 32'd1);
        bus.pend_i = 8'h24;
        tick();
        testsRun++; if (bus.cpu_irq_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL t1_irq_early got=%b exp=0", bus.cpu_irq_o); end
        tick();
        testsRun++; if (bus.cpu_irq_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL t1_irq got=%b exp=1", bus.cpu_irq_o); end
        busRead(A_CLAIM, d);
        testsRun++; if (d !== 32'h8000_0002) begin testsFailed++; $display("[TB] FAIL t1_claim got=%h exp=80000002", d); end
        testsRun++; if (bus.pend_clr_o !== 8'h04) begin testsFailed++; $display("[TB] FAIL t1_clr got=%h exp=04", bus.pend_clr_o); end
        tick();
        testsRun++; if (bus.pend_clr_o !== 8'h00) begin testsFailed++; $display("[TB] FAIL t1_clr_end got=%h exp=00", bus.pend_clr_o); end
    endtask

    task automatic test_t2_nesting();
        logic [31:0] d;
        doReset();
        busWrite(A_PRIO + 32'd8, 32'd3);
        busWrite(A_CTRL, 32'd1);
        bus.pend_i = 8'h04;
        repeat (2) tick();
        busRead(A_CLAIM, d);
        busWrite(A_PRIO + 32'd28, 32'd5);
        bus.pend_i = bus.pend_i | 8'h80;
        repeat (2) tick();
        testsRun++; if (bus.cpu_irq_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL t2_preempt_irq got=%b exp=1", bus.cpu_irq_o); end
        busRead(A_CLAIM, d);
        testsRun++; if (d !== 32'h8000_0007) begin testsFailed++; $display("[TB] FAIL t2_claim7 got=%h exp=80000007", d); end
        busRead(A_STAT, d);
        testsRun++; if (d !== 32'h2) begin testsFailed++; $display("[TB] FAIL t2_level2 got=%h exp=2", d); end
        busWrite(A_CLAIM, 32'd7);
        busWrite(A_CLAIM, 32'd2);
        busRead(A_STAT, d);
        testsRun++; if (d !== 32'h0) begin testsFailed++; $display("[TB] FAIL t2_level0 got=%h exp=0", d); end
        repeat (2) tick();
        testsRun++; if (bus.cpu_irq_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL t2_irq_off got=%b exp=0", bus.cpu_irq_o); end
    endtask

    task automatic test_t3_threshold();
        doReset();
        busWrite(A_THR, 32'd4);
        busWrite(A_PRIO + 32'd4, 32'd4);
        busWrite(A_CTRL, 32'd1);
        bus.pend_i = 8'h02;
        repeat (3) tick();
        testsRun++; if (bus.cpu_irq_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL t3_equal_thresh got=%b exp=0", bus.cpu_irq_o); end
        busWrite(A_THR, 32'd3);
        tick();
        testsRun++; if (bus.cpu_irq_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL t3_irq_1cyc got=%b exp=0", bus.cpu_irq_o); end
        tick();
        testsRun++; if (bus.cpu_irq_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL t3_irq_2cyc got=%b exp=1", bus.cpu_irq_o); end
    endtask

    task automatic test_t4_bad_complete();
        logic [31:0] d;
        doReset();
        busWrite(A_PRIO + 32'd28, 32'd5);
        busWrite(A_CTRL, 32'd1);
        bus.pend_i = 8'h80;
        repeat (2) tick();
        busRead(A_CLAIM, d);
        busWrite(A_CLAIM, 32'd2);
        busRead(A_STAT, d);
        testsRun++; if (d !== 32'h101) begin testsFailed++; $display("[TB] FAIL t4_cmpl_err got=%h exp=101", d); end
        busWrite(A_STAT, 32'h100);
        busRead(A_STAT, d);
        testsRun++; if (d !== 32'h001) begin testsFailed++; $display("[TB] FAIL t4_w1c got=%h exp=001", d); end
    endtask

    task automatic test_t5_overflow();
        logic [31:0] d;
        doReset();
        for (int k = 0; k < 5; k++) busWrite(A_PRIO + 32'(4 * k), 32'(k + 1));
        busWrite(A_CTRL, 32'd1);
        for (int k = 0; k < NEST_DEPTH; k++) begin
            bus.pend_i = bus.pend_i | NUM_CH'(1 << k);
            repeat (3) tick();
            busRead(A_CLAIM, d);
            testsRun++; if (d !== (32'h8000_0000 | 32'(k))) begin
                testsFailed++; $display("[TB] FAIL t5_claim%0d got=%h exp=%h", k, d, 32'h8000_0000 | 32'(k)); end
        end
        bus.pend_i = bus.pend_i | 8'h10;
        repeat (3) tick();
        testsRun++; if (bus.cpu_irq_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL t5_irq got=%b exp=1", bus.cpu_irq_o); end
        busRead(A_CLAIM, d);
        testsRun++; if (d !== 32'h0 || bus.pend_clr_o !== 8'h00) begin
            testsFailed++; $display("[TB] FAIL t5_ovf_claim got data=%h clr=%h exp data=0 clr=00", d, bus.pend_clr_o); end
        busRead(A_STAT, d);
        testsRun++; if (d !== 32'h204) begin testsFailed++; $display("[TB] FAIL t5_status got=%h exp=204", d); end
    endtask

    task automatic test_t6_reset_mid();
        logic [31:0] d;
        doReset();
        busWrite(A_PRIO + 32'd8, 32'd3);
        busWrite(A_PRIO + 32'd28, 32'd5);
        busWrite(A_CTRL, 32'd1);
        bus.pend_i = 8'h04;
        repeat (2) tick();
        busRead(A_CLAIM, d);
        bus.pend_i = bus.pend_i | 8'h80;
        repeat (2) tick();
        busRead(A_CLAIM, d);
        testsRun++; if ({bus.cpu_irq_o, bus.ack_o, bus.pend_clr_o} !== {1'b1, 1'b1, 8'h80}) begin
            testsFailed++; $display("[TB] FAIL t6_pre got irq=%b ack=%b clr=%h exp irq=1 ack=1 clr=80",
                                    bus.cpu_irq_o, bus.ack_o, bus.pend_clr_o); end
        #1 rstn_i = 1'b0;
        #1;
        testsRun++;
        if ({bus.cpu_irq_o, bus.ack_o, bus.data_o, bus.pend_clr_o} !== '0) begin
            testsFailed++; $display("[TB] FAIL t6_async got irq=%b ack=%b data=%h clr=%h exp all 0",
                                    bus.cpu_irq_o, bus.ack_o, bus.data_o, bus.pend_clr_o);
        end
        doReset();
        busRead(A_STAT, d);
        testsRun++; if (d !== 32'h0) begin testsFailed++; $display("[TB] FAIL t6_status got=%h exp=0", d); end
        busRead(A_PRIO + 32'd28, d);
        testsRun++; if (d !== 32'h0) begin testsFailed++; $display("[TB] FAIL t6_prio7 got=%h exp=0", d); end
    endtask

    task automatic test_random();
        int op;
        doReset();
        for (int i = 0; i < NUM_CH; i++) busWrite(A_PRIO + 32'(4 * i), 32'($urandom_range(0, 7)));
        busWrite(A_THR, 32'($urandom_range(0, 2)));
        busWrite(A_CTRL, 32'd1);
        for (int c = 0; c < 600; c++) begin
            op = $urandom_range(0, 11);
            case (op)
                0, 1: bus.pend_i = bus.pend_i | NUM_CH'($urandom);
                2: bus.pend_i = NUM_CH'($urandom);
                3: begin bus.addr_i = A_CLAIM; bus.rden_i = 1'b1; end
                4: begin bus.addr_i = A_CLAIM; bus.rden_i = 1'b1; bus.pend_i = NUM_CH'($urandom); end
                5: begin
                    bus.addr_i = A_CLAIM; bus.wren_i = 1'b1;
                    if (mStkId.size() > 0 && $urandom_range(0, 3) != 0) bus.data_i = 32'(mStkId[$]);
                    else bus.data_i = 32'($urandom_range(0, 7));
                end
                6: begin bus.addr_i = A_PRIO + 32'(4 * $urandom_range(0, 9)); bus.wren_i = 1'b1; bus.data_i = $urandom; end
                7: begin bus.addr_i = A_THR; bus.wren_i = 1'b1; bus.data_i = 32'($urandom_range(0, 4)); end
                8: begin bus.addr_i = A_STAT; bus.rden_i = 1'b1; end
                9: begin bus.addr_i = A_STAT; bus.wren_i = 1'b1; bus.data_i = 32'h300; end
                10: begin bus.addr_i = A_CTRL; bus.wren_i = 1'b1; bus.data_i = 32'($urandom_range(0, 4) != 0); end
                default: begin
                    bus.rden_i = 1'b1;
                    case ($urandom_range(0, 3))
                        0: bus.addr_i = BASE + 32'h80;
                        1: bus.addr_i = 32'h0000_0008;
                        2: bus.addr_i = A_PRIO + 32'(4 * $urandom_range(0, 9));
                        default: bus.addr_i = A_THR;
                    endcase
                end
            endcase
            tick();
            bus.rden_i = 1'b0; bus.wren_i = 1'b0;
            testsRun++;
            if ({bus.cpu_irq_o, bus.ack_o, bus.data_o, bus.pend_clr_o} !== {mIrq, mAck, mRdata, mClr}) begin
                testsFailed++;
                $display("[TB] FAIL rand_cycle%0d op=%0d got irq=%b ack=%b data=%h clr=%h exp irq=%b ack=%b data=%h clr=%h",
                         c, op, bus.cpu_irq_o, bus.ack_o, bus.data_o, bus.pend_clr_o, mIrq, mAck, mRdata, mClr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bus_map();
        test_t1_basic();
        test_t2_nesting();
        test_t3_threshold();
        test_t4_bad_complete();
        test_t5_overflow();
        test_t6_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
